// File: rtl/mod113_pkg.sv
// Shared definitions for the 200-bit mod-113 byte-stream reducer.
// Holds the modulus, byte width, frame FSM states and the byte weight helper.
package mod113_pkg;

    localparam logic [6:0] MOD_113 = 7'd113;
    localparam int         BYTE_W  = 8;

    typedef enum logic [2:0] {
        COLLECT,
        DRAIN,
        REDUCE,
        WAIT1,
        OUT
    } state_t;

    // Weight of byte k inside the operand: 256^k mod 113, evaluated at elaboration.
    function automatic logic [6:0] pow256_mod(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = (r * 256) % 113;
        end
        return 7'(r);
    endfunction

endpackage

// File: rtl/x_200_mod_113.sv
// Combinational 200-bit mod-113 reducer: X[200:1] -> R[7:1].
// Each byte is scaled by its constant weight, the partial products are summed, then reduced once.
module x_200_mod_113
    import mod113_pkg::*;
(
    input  logic [200:1] i_x,
    output logic [7:1]   o_r
);

    localparam int NBYTES = 200 / BYTE_W;

    // Largest sum is 25 * 255 * 112 = 714000, which fits in 20 bits.
    logic [19:0] w_pp [NBYTES];
    logic [19:0] w_acc;

    for (genvar g = 0; g < NBYTES; g++) begin : g_pp
        localparam logic [6:0] WT = pow256_mod(g);
        assign w_pp[g] = 20'(i_x[BYTE_W*g+1 +: BYTE_W]) * 20'(WT);
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NBYTES; k++) begin
            w_acc = w_acc + w_pp[k];
        end
        o_r = 7'(w_acc % 20'(MOD_113));
    end

endmodule

// File: rtl/x_200_mod_113_stream.sv
// Byte-stream front end for the mod-113 reducer: gathers a 25-byte operand LSB first,
// reduces it and offers the residue plus a frame-length error flag on a valid/ready port.
module x_200_mod_113_stream
    import mod113_pkg::*;
#(
    parameter int W    = 200,
    parameter int NB   = 25,
    parameter int PIPE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [6:0] out_r,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready
);

    // Both ports transfer on the cycle where valid and ready are high together;
    // out_r/out_err hold steady while out_valid waits for out_ready.

    state_t          r_state;
    state_t          w_next_state;
    logic [4:0]      r_cnt;
    logic [W-1:0]    r_x;
    logic            r_err;
    logic [6:0]      r_r_pipe;
    logic [6:0]      r_out_r;
    logic            r_out_err;
    logic [6:0]      w_core_r;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_last_slot;
    logic            w_collect_fire;
    logic [NB-1:0]   w_slot_we;

    assign in_ready       = (r_state == COLLECT) || (r_state == DRAIN);
    assign out_valid      = (r_state == OUT);
    assign w_in_fire      = in_valid & in_ready;
    assign w_out_fire     = out_valid & out_ready;
    assign w_last_slot    = (r_cnt == 5'(NB - 1));
    assign w_collect_fire = (r_state == COLLECT) && w_in_fire;
    assign out_r          = r_out_r;
    assign out_err        = r_out_err;

    always_comb begin
        for (int k = 0; k < NB; k++) begin
            w_slot_we[k] = w_collect_fire && (r_cnt == 5'(k));
        end
    end

    x_200_mod_113 u_core (
        .i_x (r_x),
        .o_r (w_core_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: begin
                if (w_in_fire) begin
                    if (in_last)         w_next_state = REDUCE;
                    else if (w_last_slot) w_next_state = DRAIN;
                end
            end
            DRAIN:   if (w_in_fire && in_last) w_next_state = REDUCE;
            REDUCE:  w_next_state = (PIPE != 0) ? WAIT1 : OUT;
            WAIT1:   w_next_state = OUT;
            OUT:     if (w_out_fire) w_next_state = COLLECT;
            default: w_next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_x       <= '0;
            r_err     <= 1'b0;
            r_r_pipe  <= '0;
            r_out_r   <= '0;
            r_out_err <= 1'b0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (w_slot_we[k]) r_x[BYTE_W*k +: BYTE_W] <= in_data;
            end
            if (w_collect_fire) begin
                r_cnt <= r_cnt + 5'd1;
                // Short frame ends early; long frame is flagged when slot NB-1 fills without last.
                if (in_last)          r_err <= !w_last_slot;
                else if (w_last_slot) r_err <= 1'b1;
            end
            if (r_state == REDUCE) begin
                r_r_pipe <= w_core_r;
                if (PIPE == 0) begin
                    r_out_r   <= w_core_r;
                    r_out_err <= r_err;
                end
            end
            if (r_state == WAIT1) begin
                r_out_r   <= r_r_pipe;
                r_out_err <= r_err;
            end
            // Clearing the operand here keeps unwritten slots of the next short frame at zero.
            if (w_out_fire) begin
                r_cnt <= '0;
                r_x   <= '0;
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_x_200_mod_113_stream.sv
// Bench for x_200_mod_113_stream: directed frames with hand-computed residues,
// then random frames scored against a byte-serial big-integer reduction.
module tb_x_200_mod_113_stream;

    localparam int NB = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [6:0] out_r;
    logic       out_err;
    logic       out_valid;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fb [0:31];

    x_200_mod_113_stream #(.W(200), .NB(25), .PIPE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_r     (out_r),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #800000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // out_ready: 0 = always high, 1 = random gaps, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL residue_unexpected: got err=%0d r=%0d, required no output", out_err, out_r);
            end else begin
                e = exp_q.pop_front();
                if ({out_err, out_r} !== e) begin
                    n_err++;
                    $display("FAIL residue: got err=%0d r=%0d, required err=%0d r=%0d",
                             out_err, out_r, e[7], e[6:0]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic logic [7:0] model(input int len);
        int r = 0;
        int n = (len < NB) ? len : NB;
        for (int k = n - 1; k >= 0; k--) begin
            r = (r * 256 + int'(fb[k])) % 113;
        end
        return {(len != NB), 7'(r)};
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 32; i++) fb[i] = v;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps, output int waited);
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit gaps);
        int w;
        for (int i = 0; i < len; i++) send_byte(fb[i], (i == len - 1), gaps, w);
    endtask

    // Counts falling edges until out_valid is seen; returns at a negedge.
    task automatic wait_out_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 300);
        check("out_valid_seen", int'(out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", int'(out_valid), 0);
        check("async_reset_out_r", int'(out_r), 0);
        check("async_reset_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n;
        int len;
        logic [7:0] e;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_r", int'(out_r), 0);
        check("reset_out_err", int'(out_err), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // X = 113 -> 0, and three cycles from last byte to out_valid
        fill(8'h00); fb[0] = 8'h71;
        exp_q.push_back(8'h00);
        send_frame(NB, 1'b0);
        wait_out_valid(n);
        check("latency_pipe1", n, 3);
        @(posedge clk); #1;

        // X = 2^200-1 -> 15
        fill(8'hFF);
        exp_q.push_back(8'd15);
        send_frame(NB, 1'b0);

        // X = 2^198 -> 4, X = 2^199 -> 8
        fill(8'h00); fb[24] = 8'h40;
        exp_q.push_back(8'd4);
        send_frame(NB, 1'b0);
        fb[24] = 8'h80;
        exp_q.push_back(8'd8);
        send_frame(NB, 1'b0);

        // Short frame 0xFF -> err, 29; then X = 113 -> 0 shows the operand was cleared
        fill(8'h00); fb[0] = 8'hFF;
        exp_q.push_back({1'b1, 7'd29});
        send_frame(1, 1'b0);
        fb[0] = 8'h71;
        exp_q.push_back(8'h00);
        send_frame(NB, 1'b0);
        drain();

        // Long frame: 27 bytes of 0x01 -> err, sum of 256^k (k<25) mod 113 = 20
        fill(8'h01);
        exp_q.push_back({1'b1, 7'd20});
        for (int i = 0; i < 27; i++) begin
            send_byte(fb[i], (i == 26), 1'b0, n);
            if (i >= 24) check($sformatf("long_in_ready_byte%0d", i), n, 0);
        end
        drain();

        // Backpressure: residue 4 must hold while out_ready stays low
        rdy_mode = 2;
        fill(8'h00); fb[24] = 8'h40;
        exp_q.push_back(8'd4);
        send_frame(NB, 1'b0);
        wait_out_valid(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_r", int'(out_r), 4);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
        end
        rdy_mode = 0;
        drain();

        // Reset while a result is pending, then reset during a partial frame
        rdy_mode = 2;
        fill(8'h00); fb[24] = 8'h80;
        send_frame(NB, 1'b0);
        wait_out_valid(n);
        #2;
        pulse_reset();
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_byte(8'hAA, 1'b0, 1'b0, n);
        pulse_reset();
        fill(8'h00); fb[0] = 8'h71;
        exp_q.push_back(8'h00);
        send_frame(NB, 1'b0);
        drain();

        // Random frames with input gaps and output backpressure
        rdy_mode = 1;
        for (int f = 0; f < 300; f++) begin
            case ($urandom_range(0, 9))
                0:       len = $urandom_range(1, NB - 1);
                1:       len = $urandom_range(NB + 1, NB + 3);
                default: len = NB;
            endcase
            for (int i = 0; i < 32; i++) fb[i] = 8'($urandom_range(0, 255));
            e = model(len);
            exp_q.push_back(e);
            send_frame(len, 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
